// File: rtl/sad_window_accumulator_if.sv
// ---------------------------------------------------------------------------
// sad_window_accumulator_if
// Purpose : absolute-difference vector bus from the stereo matching front end
//           into the SAD window accumulator. One column per valid beat.
// Signals : in_diff    - window_size lanes of num_bits unsigned differences,
//                        lane i = in_diff[num_bits*i +: num_bits]
//           in_valid   - in_diff / line_start qualify this cycle
//           line_start - with in_valid, this column starts a new image row
// Modports: master (front end, drives), slave (accumulator, receives)
// ---------------------------------------------------------------------------
interface sad_window_accumulator_if #(
    parameter int window_size = 5,
    parameter int num_bits    = 8
);
    logic [num_bits*window_size-1:0] in_diff;
    logic                            in_valid;
    logic                            line_start;

    modport master (output in_diff, in_valid, line_start);
    modport slave  (input  in_diff, in_valid, line_start);
endinterface

// File: rtl/sad_window_accumulator.sv
// ---------------------------------------------------------------------------
// sad_window_accumulator
// Purpose : turns per-column absolute-difference vectors into a sliding
//           window_size x window_size Sum of Absolute Differences, one result
//           per accepted column once a full window of the current row exists.
// Ports   : i_clock      - single clock, rising edge
//           i_reset_n    - asynchronous active-low reset
//           i_diff       - difference vector bus (slave modport)
//           o_sad        - window SAD, unsigned, holds between results
//           o_sad_valid  - one-cycle pulse per new result
//           o_sad_first  - with o_sad_valid, first result of the row
// Pipeline: column sum -> window update -> output register. A column sampled
//           on edge N shows its result after edge N+2.
// ---------------------------------------------------------------------------
module sad_window_accumulator #(
    parameter int window_size = 5,
    parameter int num_bits    = 8,
    parameter int sad_bits    = 13
) (
    input  logic                    i_clock,
    input  logic                    i_reset_n,
    sad_window_accumulator_if.slave i_diff,
    output logic [sad_bits-1:0]     o_sad,
    output logic                    o_sad_valid,
    output logic                    o_sad_first
);
    localparam int COL_BITS = num_bits + $clog2(window_size);
    localparam int CNT_BITS = $clog2(window_size + 1);
    localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(window_size);

    typedef enum logic {FILL, STREAM} state_t;

    // Stage 1 state
    logic [COL_BITS-1:0] r_col_sum;
    logic                r_v1;
    logic                r_ls1;
    // Stage 2 state
    logic [COL_BITS-1:0] r_hist [window_size];
    logic [sad_bits-1:0] r_run_sum;
    logic [CNT_BITS-1:0] r_fill_cnt;
    state_t              r_state;
    logic                r_emit;
    logic                r_emit_first;
    // Output stage
    logic [sad_bits-1:0] r_sad;
    logic                r_sad_valid;
    logic                r_sad_first;

    logic [num_bits-1:0] w_lane [window_size];
    logic [COL_BITS-1:0] w_col_sum;
    logic [sad_bits-1:0] w_run_next;
    logic [CNT_BITS-1:0] w_fill_next;
    logic                w_full;

    generate
        for (genvar gi = 0; gi < window_size; gi++) begin : g_lane
            assign w_lane[gi] = i_diff.in_diff[num_bits*gi +: num_bits];
        end
    endgenerate

    always_comb begin
        w_col_sum = '0;
        for (int i = 0; i < window_size; i++) begin
            w_col_sum = w_col_sum + COL_BITS'(w_lane[i]);
        end
    end

    // The final sum always fits in sad_bits, so modular add/subtract at that
    // width is exact even if the add alone momentarily exceeded it.
    always_comb begin
        if (r_ls1) begin
            w_run_next  = sad_bits'(r_col_sum);
            w_fill_next = CNT_BITS'(1);
        end else begin
            w_run_next  = r_run_sum + sad_bits'(r_col_sum)
                        - sad_bits'(r_hist[window_size-1]);
            w_fill_next = (r_fill_cnt == FULL_CNT) ? r_fill_cnt
                                                   : r_fill_cnt + CNT_BITS'(1);
        end
        w_full = (w_fill_next == FULL_CNT);
    end

    // Stage 1: column sum. Bubbles clear v1 but leave the sum alone.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_col_sum <= '0;
            r_v1      <= 1'b0;
            r_ls1     <= 1'b0;
        end else if (i_diff.in_valid) begin
            r_col_sum <= w_col_sum;
            r_v1      <= 1'b1;
            r_ls1     <= i_diff.line_start;
        end else begin
            r_v1      <= 1'b0;
            r_ls1     <= 1'b0;
        end
    end

    // Stage 2: history shift, running sum and fill/stream state machine.
    // A row start zeroes the history so the oldest entry reads 0 while
    // the window refills.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < window_size; i++) r_hist[i] <= '0;
            r_run_sum    <= '0;
            r_fill_cnt   <= '0;
            r_state      <= FILL;
            r_emit       <= 1'b0;
            r_emit_first <= 1'b0;
        end else if (r_v1) begin
            r_hist[0] <= r_col_sum;
            for (int i = 1; i < window_size; i++) begin
                r_hist[i] <= r_ls1 ? '0 : r_hist[i-1];
            end
            r_run_sum    <= w_run_next;
            r_fill_cnt   <= w_fill_next;
            r_state      <= w_full ? STREAM : FILL;
            r_emit       <= w_full;
            r_emit_first <= w_full && (r_ls1 || (r_state == FILL));
        end else begin
            r_emit       <= 1'b0;
            r_emit_first <= 1'b0;
        end
    end

    // Output register: sad only changes when a new result is published.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sad       <= '0;
            r_sad_valid <= 1'b0;
            r_sad_first <= 1'b0;
        end else begin
            r_sad_valid <= r_emit;
            r_sad_first <= r_emit_first;
            if (r_emit) r_sad <= r_run_sum;
        end
    end

    assign o_sad       = r_sad;
    assign o_sad_valid = r_sad_valid;
    assign o_sad_first = r_sad_first;
endmodule

// File: tb/tb_sad_window_accumulator.sv
module tb_sad_window_accumulator;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [12:0] o_sad;
    logic        o_sad_valid;
    logic        o_sad_first;
    int          tests_run = 0;
    int          tests_failed = 0;

    sad_window_accumulator_if #(.window_size(5), .num_bits(8)) dif ();

    sad_window_accumulator #(.window_size(5), .num_bits(8), .sad_bits(13)) dut (
        .i_clock     (clk),
        .i_reset_n   (rst_n),
        .i_diff      (dif),
        .o_sad       (o_sad),
        .o_sad_valid (o_sad_valid),
        .o_sad_first (o_sad_first)
    );

    always #5 clk = ~clk;

    // Drive one cycle of input (all lanes equal), then advance to 1 time unit
    // past the next rising edge where outputs are sampled.
    task automatic cycle(input bit v, input bit ls, input int lane);
        logic [7:0] l;
        l = 8'(lane);
        dif.in_valid   = v;
        dif.line_start = ls;
        dif.in_diff    = {5{l}};
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int c = 0; c < 10; c++) begin
            dif.in_valid   = 1'($urandom_range(0, 1));
            dif.line_start = 1'($urandom_range(0, 1));
            dif.in_diff    = 40'({$urandom(), $urandom()});
            @(posedge clk);
            #1;
            tests_run++;
            if (o_sad !== 13'd0 || o_sad_valid !== 1'b0 || o_sad_first !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_hold c%0d: sad=%0d valid=%0b first=%0b, expected 0 0 0",
                         c, o_sad, o_sad_valid, o_sad_first);
            end
        end
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cycle(1'b0, 1'b0, 0);
            tests_run++;
            if (o_sad !== 13'd0 || o_sad_valid !== 1'b0 || o_sad_first !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_idle c%0d: sad=%0d valid=%0b first=%0b, expected 0 0 0",
                         c, o_sad, o_sad_valid, o_sad_first);
            end
        end
    endtask

    task automatic test_constant_fill();
        bit sv [9] = '{1,1,1,1,1,1,1,0,0};
        bit sl [9] = '{1,0,0,0,0,0,0,0,0};
        int sd [9] = '{1,1,1,1,1,1,1,0,0};
        bit ev [9] = '{0,0,0,0,0,0,1,1,1};
        bit ef [9] = '{0,0,0,0,0,0,1,0,0};
        int es [9] = '{0,0,0,0,0,0,25,25,25};
        for (int c = 0; c < 9; c++) begin
            cycle(sv[c], sl[c], sd[c]);
            tests_run++;
            if (o_sad_valid !== ev[c] || o_sad_first !== ef[c] ||
                (ev[c] && o_sad !== 13'(es[c]))) begin
                tests_failed++;
                $display("FAIL const_fill c%0d: valid=%0b first=%0b sad=%0d, expected valid=%0b first=%0b sad=%0d",
                         c, o_sad_valid, o_sad_first, o_sad, ev[c], ef[c], es[c]);
            end
        end
    endtask

    task automatic test_sliding();
        bit sv [9] = '{1,1,1,1,1,1,1,0,0};
        bit sl [9] = '{1,0,0,0,0,0,0,0,0};
        int sd [9] = '{1,2,3,4,5,6,7,0,0};
        bit ev [9] = '{0,0,0,0,0,0,1,1,1};
        bit ef [9] = '{0,0,0,0,0,0,1,0,0};
        int es [9] = '{0,0,0,0,0,0,75,100,125};
        for (int c = 0; c < 9; c++) begin
            cycle(sv[c], sl[c], sd[c]);
            tests_run++;
            if (o_sad_valid !== ev[c] || o_sad_first !== ef[c] ||
                (ev[c] && o_sad !== 13'(es[c]))) begin
                tests_failed++;
                $display("FAIL sliding c%0d: valid=%0b first=%0b sad=%0d, expected valid=%0b first=%0b sad=%0d",
                         c, o_sad_valid, o_sad_first, o_sad, ev[c], ef[c], es[c]);
            end
        end
    endtask

    task automatic test_max_range();
        bit sv [8] = '{1,1,1,1,1,1,0,0};
        bit sl [8] = '{1,0,0,0,0,0,0,0};
        int sd [8] = '{255,255,255,255,255,255,0,0};
        bit ev [8] = '{0,0,0,0,0,0,1,1};
        bit ef [8] = '{0,0,0,0,0,0,1,0};
        int es [8] = '{0,0,0,0,0,0,6375,6375};
        for (int c = 0; c < 8; c++) begin
            cycle(sv[c], sl[c], sd[c]);
            tests_run++;
            if (o_sad_valid !== ev[c] || o_sad_first !== ef[c] ||
                (ev[c] && o_sad !== 13'(es[c]))) begin
                tests_failed++;
                $display("FAIL max_range c%0d: valid=%0b first=%0b sad=%0d, expected valid=%0b first=%0b sad=%0d",
                         c, o_sad_valid, o_sad_first, o_sad, ev[c], ef[c], es[c]);
            end
        end
    endtask

    // Bubble cycles carry junk lane data (9) that must be ignored.
    task automatic test_bubbles();
        bit sv [13] = '{1,1,1,0,0,0,1,1,1,0,1,0,0};
        bit sl [13] = '{1,0,0,0,0,0,0,0,0,0,0,0,0};
        int sd [13] = '{1,2,3,9,9,9,4,5,6,9,7,0,0};
        bit ev [13] = '{0,0,0,0,0,0,0,0,0,1,1,0,1};
        bit ef [13] = '{0,0,0,0,0,0,0,0,0,1,0,0,0};
        int es [13] = '{0,0,0,0,0,0,0,0,0,75,100,0,125};
        for (int c = 0; c < 13; c++) begin
            cycle(sv[c], sl[c], sd[c]);
            tests_run++;
            if (o_sad_valid !== ev[c] || o_sad_first !== ef[c] ||
                (ev[c] && o_sad !== 13'(es[c]))) begin
                tests_failed++;
                $display("FAIL bubbles c%0d: valid=%0b first=%0b sad=%0d, expected valid=%0b first=%0b sad=%0d",
                         c, o_sad_valid, o_sad_first, o_sad, ev[c], ef[c], es[c]);
            end
        end
    endtask

    // New row starts right behind column 7; its in-flight results still emit.
    task automatic test_row_restart();
        bit sv [14] = '{1,1,1,1,1,1,1,1,1,1,1,1,0,0};
        bit sl [14] = '{1,0,0,0,0,0,0,1,0,0,0,0,0,0};
        int sd [14] = '{1,2,3,4,5,6,7,2,2,2,2,2,0,0};
        bit ev [14] = '{0,0,0,0,0,0,1,1,1,0,0,0,0,1};
        bit ef [14] = '{0,0,0,0,0,0,1,0,0,0,0,0,0,1};
        int es [14] = '{0,0,0,0,0,0,75,100,125,0,0,0,0,50};
        for (int c = 0; c < 14; c++) begin
            cycle(sv[c], sl[c], sd[c]);
            tests_run++;
            if (o_sad_valid !== ev[c] || o_sad_first !== ef[c] ||
                (ev[c] && o_sad !== 13'(es[c]))) begin
                tests_failed++;
                $display("FAIL row_restart c%0d: valid=%0b first=%0b sad=%0d, expected valid=%0b first=%0b sad=%0d",
                         c, o_sad_valid, o_sad_first, o_sad, ev[c], ef[c], es[c]);
            end
        end
    endtask

    task automatic test_reset_mid_row();
        bit sv [7] = '{1,1,1,1,1,0,0};
        int sd [7] = '{3,3,3,3,3,0,0};
        bit ev [7] = '{0,0,0,0,0,0,1};
        bit ef [7] = '{0,0,0,0,0,0,1};
        int es [7] = '{0,0,0,0,0,0,75};
        cycle(1'b1, 1'b1, 2);
        cycle(1'b1, 1'b0, 2);
        cycle(1'b1, 1'b0, 2);
        tests_run++;
        if (o_sad !== 13'd50 || o_sad_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_row_hold: sad=%0d valid=%0b, expected sad=50 valid=0",
                     o_sad, o_sad_valid);
        end
        dif.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (o_sad !== 13'd0 || o_sad_valid !== 1'b0 || o_sad_first !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_row_async_clear: sad=%0d valid=%0b first=%0b, expected 0 0 0",
                     o_sad, o_sad_valid, o_sad_first);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // No line_start: after reset the first columns count as a row start.
        for (int c = 0; c < 7; c++) begin
            cycle(sv[c], 1'b0, sd[c]);
            tests_run++;
            if (o_sad_valid !== ev[c] || o_sad_first !== ef[c] ||
                (ev[c] && o_sad !== 13'(es[c]))) begin
                tests_failed++;
                $display("FAIL after_reset c%0d: valid=%0b first=%0b sad=%0d, expected valid=%0b first=%0b sad=%0d",
                         c, o_sad_valid, o_sad_first, o_sad, ev[c], ef[c], es[c]);
            end
        end
    endtask

    initial begin
        dif.in_valid   = 1'b0;
        dif.line_start = 1'b0;
        dif.in_diff    = '0;
        #1;
        test_reset();
        test_constant_fill();
        test_sliding();
        test_max_range();
        test_bubbles();
        test_row_restart();
        test_reset_mid_row();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
